// File: rtl/alu_16bit_stim_gen.sv
// Stimulus sequencer for the 16-bit ALU: LFSR-driven random vectors per opcode, then a fixed
// edge-case table, presented over a valid/ready handshake.
module alu_16bit_stim_gen #(
   parameter int unsigned SAMPLES_PER_OP = 512,
   parameter logic [31:0] SEED           = 32'h0000_007B
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        ready,
   output logic [15:0] A,
   output logic [15:0] B,
   output logic [1:0]  op,
   output logic        valid,
   output logic        busy,
   output logic        done,
   output logic [11:0] vec_count
);

   localparam logic [31:0] Taps       = 32'h8020_0003;
   localparam logic [31:0] SeedEff    = (SEED == 32'd0) ? 32'd1 : SEED;
   localparam logic [9:0]  LastSample = 10'(SAMPLES_PER_OP - 1);
   localparam logic [2:0]  LastEdge   = 3'd5;

   typedef enum logic [1:0] {StIdle, StRandom, StEdge, StDone} state_e;

   state_e      state_q, state_d;
   logic [31:0] lfsr_q, lfsr_d;
   logic [15:0] a_q, a_d;
   logic [15:0] b_q, b_d;
   logic [1:0]  op_q, op_d;
   logic [9:0]  sample_q, sample_d;
   logic [2:0]  edge_q, edge_d;
   logic [11:0] count_q, count_d;
   logic [31:0] lfsr_next;
   logic [33:0] edge_vec;
   logic [2:0]  edge_sel;

   function automatic logic [31:0] lfsr_step(input logic [31:0] s);
      return s[0] ? ((s >> 1) ^ Taps) : (s >> 1);
   endfunction

   // {A, B, op} for each entry of the fixed edge-case table
   function automatic logic [33:0] edge_entry(input logic [2:0] idx);
      logic [33:0] v;
      case (idx)
         3'd0:    v = {16'hFFFF, 16'hFFFF, 2'b00};
         3'd1:    v = {16'h0000, 16'h0000, 2'b00};
         3'd2:    v = {16'hFFFF, 16'h0001, 2'b01};
         3'd3:    v = {16'hAAAA, 16'h5555, 2'b10};
         3'd4:    v = {16'hAAAA, 16'h5555, 2'b11};
         3'd5:    v = {16'h8000, 16'h8000, 2'b00};
         default: v = '0;
      endcase
      return v;
   endfunction

   assign lfsr_next = lfsr_step(lfsr_q);

   always_comb begin
      edge_sel = 3'd0;
      if (state_q == StEdge) begin
         edge_sel = edge_q + 3'd1;
      end
   end

   assign edge_vec = edge_entry(edge_sel);

   always_comb begin
      state_d  = state_q;
      lfsr_d   = lfsr_q;
      a_d      = a_q;
      b_d      = b_q;
      op_d     = op_q;
      sample_d = sample_q;
      edge_d   = edge_q;
      count_d  = count_q;

      unique case (state_q)
         StIdle, StDone: begin
            if (start) begin
               state_d  = StRandom;
               lfsr_d   = SeedEff;
               a_d      = SeedEff[31:16];
               b_d      = SeedEff[15:0];
               op_d     = 2'd0;
               sample_d = 10'd0;
               edge_d   = 3'd0;
               count_d  = 12'd0;
            end
         end

         StRandom: begin
            if (ready) begin
               count_d = count_q + 12'd1;
               lfsr_d  = lfsr_next;
               a_d     = lfsr_next[31:16];
               b_d     = lfsr_next[15:0];
               if (sample_q == LastSample) begin
                  sample_d = 10'd0;
                  if (op_q == 2'd3) begin
                     // Last random sample accepted: switch to the edge table, entry 0
                     state_d            = StEdge;
                     edge_d             = 3'd0;
                     {a_d, b_d, op_d}   = edge_vec;
                  end else begin
                     op_d = op_q + 2'd1;
                  end
               end else begin
                  sample_d = sample_q + 10'd1;
               end
            end
         end

         StEdge: begin
            if (ready) begin
               count_d = count_q + 12'd1;
               if (edge_q == LastEdge) begin
                  // A/B/op intentionally keep the final edge vector
                  state_d = StDone;
               end else begin
                  edge_d           = edge_q + 3'd1;
                  {a_d, b_d, op_d} = edge_vec;
               end
            end
         end

         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         lfsr_q   <= SeedEff;
         a_q      <= 16'd0;
         b_q      <= 16'd0;
         op_q     <= 2'd0;
         sample_q <= 10'd0;
         edge_q   <= 3'd0;
         count_q  <= 12'd0;
      end else begin
         state_q  <= state_d;
         lfsr_q   <= lfsr_d;
         a_q      <= a_d;
         b_q      <= b_d;
         op_q     <= op_d;
         sample_q <= sample_d;
         edge_q   <= edge_d;
         count_q  <= count_d;
      end
   end

   assign A         = a_q;
   assign B         = b_q;
   assign op        = op_q;
   assign valid     = (state_q == StRandom) || (state_q == StEdge);
   assign busy      = valid;
   assign done      = (state_q == StDone);
   assign vec_count = count_q;

endmodule

// File: tb/tb_alu_16bit_stim_gen.sv
// Bench for alu_16bit_stim_gen: a directed vector table, then random-ready runs checked
// cycle by cycle against a vector-index reference model.
module tb_alu_16bit_stim_gen;

   localparam int unsigned Spo   = 512;
   localparam int unsigned Total = 4 * Spo + 6;
   localparam logic [31:0] Seed  = 32'h0000_007B;

   logic        clk = 1'b0;
   logic        rst_n, start, ready;
   logic [15:0] A, B;
   logic [1:0]  op;
   logic        valid, busy, done;
   logic [11:0] vec_count;

   int errors = 0;
   int checks = 0;

   // Model: 0 idle, 1 running, 2 done; m_k = transfers so far; m_lfsr = value behind vector m_k
   int          m_state;
   int          m_k;
   logic [31:0] m_lfsr;

   alu_16bit_stim_gen #(
      .SAMPLES_PER_OP(Spo),
      .SEED          (Seed)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .ready    (ready),
      .A        (A),
      .B        (B),
      .op       (op),
      .valid    (valid),
      .busy     (busy),
      .done     (done),
      .vec_count(vec_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        r;
      logic        s;
      logic        rd;
      logic [48:0] exp;
      string       name;
   } vec_t;

   vec_t tbl[7];

   function automatic logic [31:0] step(input logic [31:0] s);
      return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
   endfunction

   function automatic logic [33:0] edge_entry(input int i);
      case (i)
         0:       return {16'hFFFF, 16'hFFFF, 2'd0};
         1:       return {16'h0000, 16'h0000, 2'd0};
         2:       return {16'hFFFF, 16'h0001, 2'd1};
         3:       return {16'hAAAA, 16'h5555, 2'd2};
         4:       return {16'hAAAA, 16'h5555, 2'd3};
         5:       return {16'h8000, 16'h8000, 2'd0};
         default: return '0;
      endcase
   endfunction

   function automatic logic [48:0] actual();
      return {A, B, op, valid, busy, done, vec_count};
   endfunction

   function automatic logic [48:0] expected();
      logic [33:0] v;
      if (m_state == 0) return '0;
      if (m_state == 2) return {16'h8000, 16'h8000, 2'd0, 3'b001, 12'(Total)};
      if (m_k < int'(4 * Spo)) v = {m_lfsr, 2'(m_k / int'(Spo))};
      else                    v = edge_entry(m_k - int'(4 * Spo));
      return {v, 3'b110, 12'(m_k)};
   endfunction

   task automatic model_update(input logic r, input logic s, input logic rd);
      if (!r) begin
         m_state = 0;
         m_k     = 0;
      end else if (m_state != 1 && s) begin
         m_state = 1;
         m_k     = 0;
         m_lfsr  = Seed;
      end else if (m_state == 1 && rd) begin
         if (m_k < int'(4 * Spo)) m_lfsr = step(m_lfsr);
         m_k++;
         if (m_k == int'(Total)) m_state = 2;
      end
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (vec_count=%0d)", name, act, exp, vec_count);
      end
   endtask

   task automatic apply(input logic r, input logic s, input logic rd);
      rst_n = r;
      start = s;
      ready = rd;
      model_update(r, s, rd);
      @(posedge clk);
      #1;
   endtask

   task automatic cycle(input logic r, input logic s, input logic rd, input string name);
      apply(r, s, rd);
      check(name, 64'(actual()), 64'(expected()));
   endtask

   initial begin
      int  cyc;
      int  n;
      bit  held;
      rst_n = 1'b0;
      start = 1'b0;
      ready = 1'b0;
      m_state = 0;
      m_k     = 0;
      m_lfsr  = Seed;

      tbl[0] = '{1'b0, 1'b0, 1'b0, {16'h0000, 16'h0000, 2'd0, 3'b000, 12'd0}, "reset"};
      tbl[1] = '{1'b1, 1'b0, 1'b1, {16'h0000, 16'h0000, 2'd0, 3'b000, 12'd0}, "idle_ready"};
      tbl[2] = '{1'b1, 1'b1, 1'b1, {16'h0000, 16'h007B, 2'd0, 3'b110, 12'd0}, "start_first"};
      tbl[3] = '{1'b1, 1'b0, 1'b0, {16'h0000, 16'h007B, 2'd0, 3'b110, 12'd0}, "stall_first"};
      tbl[4] = '{1'b1, 1'b0, 1'b1, {16'h8020, 16'h003E, 2'd0, 3'b110, 12'd1}, "xfer1"};
      tbl[5] = '{1'b1, 1'b0, 1'b0, {16'h8020, 16'h003E, 2'd0, 3'b110, 12'd1}, "stall2"};
      tbl[6] = '{1'b1, 1'b0, 1'b1, {16'h4010, 16'h001F, 2'd0, 3'b110, 12'd2}, "xfer2"};

      for (int i = 0; i < 7; i++) begin
         apply(tbl[i].r, tbl[i].s, tbl[i].rd);
         check(tbl[i].name, 64'(actual()), 64'(tbl[i].exp));
      end

      // Random ready, a 5-cycle stall, start pulses while busy (all must be ignored)
      cyc  = 0;
      held = 1'b0;
      while (m_state == 1 && cyc < 20000) begin
         if (m_k == 300 && !held) begin
            held = 1'b1;
            for (int j = 0; j < 5; j++) cycle(1'b1, 1'b0, 1'b0, "stall5");
         end else if (m_k == 100) begin
            cycle(1'b1, 1'b1, 1'b1, "start_at_100");
         end else begin
            cycle(1'b1, ($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0), "random_run");
         end
         cyc++;
      end
      check("run_reached_done", 64'(done), 64'(1));

      // Restart from DONE, then ready tied high for the whole run
      cycle(1'b1, 1'b1, 1'b0, "restart_from_done");
      check("restart_vector", 64'({A, B}), 64'h0000_007B);
      n = 0;
      while (!done && n < 5000) begin
         cycle(1'b1, 1'b0, 1'b1, "ready_tied");
         n++;
         if (vec_count == 12'd512)  check("op_at_512", 64'(op), 64'(1));
         if (vec_count == 12'd1024) check("op_at_1024", 64'(op), 64'(2));
         if (vec_count == 12'd1536) check("op_at_1536", 64'(op), 64'(3));
         if (vec_count == 12'd2048) check("edge0_at_2048", 64'({A, B}), 64'hFFFF_FFFF);
      end
      check("done_latency", 64'(n), 64'(2054));
      check("done_valid", 64'({done, valid}), 64'(2'b10));

      // Reset in the middle of a run
      cycle(1'b1, 1'b1, 1'b1, "restart2");
      cyc = 0;
      while (m_k < 700 && cyc < 2000) begin
         cycle(1'b1, 1'b0, 1'b1, "to_700");
         cyc++;
      end
      check("reached_700", 64'(vec_count), 64'(700));
      cycle(1'b0, 1'b0, 1'b1, "mid_reset");
      check("mid_reset_outputs", 64'(actual()), 64'(0));
      cycle(1'b1, 1'b0, 1'b1, "idle_after_reset");
      cycle(1'b1, 1'b1, 1'b0, "start_after_reset");
      check("reset_restart_vector", 64'({A, B, op, vec_count}), 64'({32'h0000_007B, 2'd0, 12'd0}));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
